blinker: RTL and testbench
==========================

Name: blinker

Overview:
- Free-running pattern generator that drives an OUTPUT_WIDTH-bit bus, typically board LEDs.
- All output bits toggle together, so the bus alternates between all-zeros and all-ones.
- Toggle rate is set by a compile-time clock-divide parameter. The default toggles every clock cycle.
- Sits at top level, fed directly by the board clock; it has no other inputs.

Parameters:
- OUTPUT_WIDTH, 4: width of out; legal range 1 and up.
- DIVIDE, 1: number of clk rising edges between successive toggles; legal range 1 and up.
- INIT, 1'b0: value every bit of out takes at power-up and after reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- out  output  OUTPUT_WIDTH  blink pattern; all bits always equal.

Behaviour:
- State:
  - out register, OUTPUT_WIDTH bits.
  - Divide counter cnt, width clog2(DIVIDE) with minimum 1 bit. When DIVIDE=1 the counter is absent or held at 0.
- Power-up:
  - out initialises to all bits = INIT and cnt to 0, via register initial values.
  - The block must blink correctly with rst never asserted, or left unconnected (z is treated as deasserted).
- Reset: on a rising clk edge with rst=1:
  - out <= all bits INIT; cnt <= 0.
  - Reset has priority over a toggle due on the same edge.
  - Releasing rst mid-count restarts the divide period from 0.
- Normal operation, on each rising clk edge with rst=0:
  - If cnt == DIVIDE-1: out <= ~out and cnt <= 0.
  - Otherwise: cnt <= cnt+1 and out holds.
- DIVIDE=1: out inverts on every rising edge. This gives a square wave of period 2 clk cycles with 50% duty.
- General DIVIDE: the first toggle occurs on the DIVIDE-th rising edge after power-up or reset release. The output period is 2*DIVIDE clk cycles.
- Latency: out changes only on rising clk edges, as a registered output with no combinational path from any input.
- Bit coherence: all out bits are identical at every instant; there are no partial-bus transitions.
- Wrap-around: the counter never exceeds DIVIDE-1, and out toggles indefinitely with no terminal state.

Test Plan:
- Sanity, OUTPUT_WIDTH=4, DIVIDE=1, INIT=0, rst held 0, 10 ns clk starting low (rising edges at 5, 15, 25 ns …):
  - out=0000 before the first edge.
  - Sampled at 10, 20, 30 … ns, out must read 1111, 0000, 1111 … for 10 consecutive checks.
- Bits never differ: across 100 cycles, assert out is always all-0 or all-1 for OUTPUT_WIDTH=4 and OUTPUT_WIDTH=1.
- Reset mid-operation, DIVIDE=1:
  - Assert rst for 3 edges while out=1111 → out=0000 on the first rst edge and stays 0000.
  - Deassert → out=1111 on the next edge.
- DIVIDE=4, INIT=0:
  - out=0000 for edges 1–3, 1111 on edge 4, 0000 on edge 8.
  - Period is 8 cycles.
- DIVIDE=4 with rst pulsed on edge 2 → cnt restarts; the next toggle lands on the 4th edge after rst deasserts.
- INIT=1, DIVIDE=1 → out=1111 at power-up and after reset, 0000 on the first post-reset edge.

Source files
------------

// File: rtl/blinker.sv
// blinker: free-running divided square wave driving every bit of a bus in lockstep
module blinker #(
    parameter int   OUTPUT_WIDTH = 4,
    parameter int   DIVIDE       = 1,
    parameter logic INIT         = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic [OUTPUT_WIDTH-1:0] out
);
    localparam int CW = DIVIDE > 1 ? $clog2(DIVIDE) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIVIDE - 1);
    logic [OUTPUT_WIDTH-1:0] out_q = {OUTPUT_WIDTH{INIT}};
    logic [OUTPUT_WIDTH-1:0] out_d;
    logic [CW-1:0]           cnt_q = '0;
    logic [CW-1:0]           cnt_d;
    logic                    wrap;
    // toggle the whole bus when the divide period ends, otherwise advance the counter
    always_comb begin
        wrap  = cnt_q == LAST;
        out_d = wrap ? ~out_q : out_q;
        cnt_d = wrap ? '0 : cnt_q + CW'(1);
    end
    // reset wins over a toggle due on the same edge and restarts the period
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= {OUTPUT_WIDTH{INIT}};
            cnt_q <= '0;
        end else begin
            out_q <= out_d;
            cnt_q <= cnt_d;
        end
    end
    assign out = out_q;
endmodule

// File: tb/tb_blinker.sv
// tb_blinker: randomized-reset scoreboard check of several blinker configurations
module tb_blinker;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rst_off = 1'b0;
    logic [3:0] out_a, out_b, out_d, out_e;
    logic       out_c;
    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0] a, b, d, e;
        logic       c;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    blinker #(.OUTPUT_WIDTH(4), .DIVIDE(1), .INIT(1'b0)) u_a (.clk(clk), .rst(rst),     .out(out_a));
    blinker #(.OUTPUT_WIDTH(4), .DIVIDE(4), .INIT(1'b0)) u_b (.clk(clk), .rst(rst),     .out(out_b));
    blinker #(.OUTPUT_WIDTH(1), .DIVIDE(3), .INIT(1'b1)) u_c (.clk(clk), .rst(rst),     .out(out_c));
    blinker #(.OUTPUT_WIDTH(4), .DIVIDE(1), .INIT(1'b1)) u_d (.clk(clk), .rst(rst),     .out(out_d));
    blinker #(.OUTPUT_WIDTH(4), .DIVIDE(5), .INIT(1'b0)) u_e (.clk(clk), .rst(rst_off), .out(out_e));

    // value after n edges since power-up or reset: INIT flipped once per full divide period
    function automatic logic lvl(int n, int div, logic init);
        return init ^ logic'((n / div) % 2);
    endfunction

    function automatic exp_t model(int n_r, int n_e);
        exp_t x;
        x.a = {4{lvl(n_r, 1, 1'b0)}};
        x.b = {4{lvl(n_r, 4, 1'b0)}};
        x.c = lvl(n_r, 3, 1'b1);
        x.d = {4{lvl(n_r, 1, 1'b1)}};
        x.e = {4{lvl(n_e, 5, 1'b0)}};
        return x;
    endfunction

    task automatic chk(string name, logic [3:0] act, logic [3:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, req);
        end
    endtask

    // monitor: every output sample away from the rising edge is checked against the oldest prediction
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            chk("a_w4_d1_i0", out_a, x.a);
            chk("b_w4_d4_i0", out_b, x.b);
            chk("c_w1_d3_i1", {3'b000, out_c}, {3'b000, x.c});
            chk("d_w4_d1_i1", out_d, x.d);
            chk("e_w4_d5_norst", out_e, x.e);
        end
    end

    initial begin
        int n_r = 0;
        int n_e = 0;
        exp_t x;
        #1;
        x = model(0, 0);
        chk("powerup_a", out_a, x.a);
        chk("powerup_b", out_b, x.b);
        chk("powerup_c", {3'b000, out_c}, {3'b000, x.c});
        chk("powerup_d", out_d, x.d);
        chk("powerup_e", out_e, x.e);
        for (int c = 0; c < 400; c++) begin
            if (c > 0) @(negedge clk);
            if (c < 11) rst = 1'b0;
            else if (c < 14) rst = 1'b1;
            else if (c < 20) rst = 1'b0;
            else if (c == 20) rst = 1'b1;
            else if (c < 32) rst = 1'b0;
            else rst = ($urandom_range(0, 9) == 0);
            @(posedge clk);
            n_r = rst ? 0 : n_r + 1;
            n_e++;
            sb.push_back(model(n_r, n_e));
        end
        repeat (2) @(posedge clk);
        #7;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d predictions unchecked, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
